// File: rtl/msm_reg_initiator.sv
// rtl/msm_reg_initiator.sv - emesh register-access initiator with command FIFO and read response channel
//
// Accepts register read/write commands on a valid/ready channel, queues them in
// a small FIFO and turns each one into a single-cycle reg_access/reg_packet
// transaction. Read data is sampled RD_LAT cycles after the issue cycle and
// returned on a valid/ready response channel.
//
// Ports:
//   clk, rst                  clock (rising edge) and asynchronous active-high reset
//   cmd_valid / cmd_ready     command handshake; cmd_ready is simply "FIFO not full"
//   cmd_write, cmd_datamode,
//   cmd_addr, cmd_wdata       command payload (wdata ignored for reads)
//   rsp_valid / rsp_ready     read response handshake
//   rsp_rdata                 captured read data, held until the next read or reset
//   reg_access, reg_packet    registered transaction strobe and emesh packet
//   reg_rdata                 responder read data
//   busy                      FIFO non-empty or FSM not idle
//   wr_count                  completed writes, saturating
module msm_reg_initiator #(
    parameter int            AW     = 32,
    parameter int            PW     = 2*AW+40,
    parameter int            DEPTH  = 4,
    parameter int            RD_LAT = 1,
    parameter logic [AW-1:0] SRC_ID = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [1:0]    cmd_datamode,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          reg_access,
    output logic [PW-1:0] reg_packet,
    input  logic [31:0]   reg_rdata,
    output logic          busy,
    output logic [15:0]   wr_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = 3 + 2*AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO. The extra pointer bit distinguishes full from empty
    // when the index bits match, so wrap-around needs no occupancy counter.
    // ------------------------------------------------------------------
    logic [CW-1:0]  fifo_mem [DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage carries no reset: occupancy is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= {cmd_write, cmd_datamode, cmd_addr, cmd_wdata};
        end
    end

    logic [CW-1:0] head;
    logic          head_write;
    logic [1:0]    head_dm;
    logic [AW-1:0] head_addr;
    logic [AW-1:0] head_wdata;

    assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign head_write = head[CW-1];
    assign head_dm    = head[CW-2:CW-3];
    assign head_addr  = head[2*AW-1:AW];
    assign head_wdata = head[AW-1:0];

    // ------------------------------------------------------------------
    // Transaction FSM. All bus-facing outputs are registered; the combinational
    // process computes their next values alongside the next state.
    // ------------------------------------------------------------------
    state_t        state_q;
    state_t        state_d;
    logic [2:0]    lat_q;
    logic [2:0]    lat_d;
    logic          cur_write_q;
    logic          cur_write_d;
    logic          access_d;
    logic [PW-1:0] packet_d;
    logic          rsp_valid_d;
    logic [31:0]   rsp_rdata_d;
    logic [15:0]   wr_count_d;

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        cur_write_d = cur_write_q;
        access_d    = 1'b0;
        packet_d    = '0;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        wr_count_d  = wr_count;
        pop         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    access_d    = 1'b1;
                    // Layout LSB first: write, datamode, ctrlmode, dstaddr, data, srcaddr.
                    packet_d    = {SRC_ID,
                                   (head_write ? head_wdata : {AW{1'b0}}),
                                   head_addr,
                                   5'b00000,
                                   head_dm,
                                   head_write};
                    cur_write_d = head_write;
                    state_d     = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (cur_write_q) begin
                    if (wr_count != 16'hFFFF) begin
                        wr_count_d = wr_count + 16'd1;
                    end
                    state_d = S_IDLE;
                end else begin
                    lat_d   = 3'(RD_LAT);
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                // Counter holds RD_LAT in the first WAIT cycle, so the sample
                // lands exactly RD_LAT edges after the issue cycle ended.
                if (lat_q == 3'd1) begin
                    rsp_rdata_d = reg_rdata;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lat_q       <= '0;
            cur_write_q <= 1'b0;
            reg_access  <= 1'b0;
            reg_packet  <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            wr_count    <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            cur_write_q <= cur_write_d;
            reg_access  <= access_d;
            reg_packet  <= packet_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            wr_count    <= wr_count_d;
        end
    end

    assign busy = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_msm_reg_initiator.sv
// tb/tb_msm_reg_initiator.sv - self-checking bench for msm_reg_initiator
module tb_msm_reg_initiator;

    localparam int          AW     = 32;
    localparam int          PW     = 104;
    localparam int          DEPTH  = 4;
    localparam int          RD_LAT = 1;
    localparam logic [31:0] SRC_ID = 32'h5EC0_0001;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [1:0]    cmd_datamode;
    logic [31:0]   cmd_addr;
    logic [31:0]   cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          reg_access;
    logic [PW-1:0] reg_packet;
    logic [31:0]   reg_rdata;
    logic          busy;
    logic [15:0]   wr_count;

    msm_reg_initiator #(
        .AW(AW), .PW(PW), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .SRC_ID(SRC_ID)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_datamode(cmd_datamode), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .reg_access(reg_access), .reg_packet(reg_packet), .reg_rdata(reg_rdata),
        .busy(busy), .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [1:0]  dm;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        logic        write;
        logic [1:0]  dm;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] exp_data;
        logic [31:0] exp_rsp;
    } vec_t;

    int          n_pass;
    int          n_total;
    int          cyc;
    logic [31:0] hist [int];
    cmd_t        exp_q [$];
    bit          outstanding;
    int          issue_cyc;
    bit          prev_access;
    bit          prev_rv;
    bit          prev_rr;
    logic [31:0] prev_rd;
    int          n_wr_issued;
    int          n_accepted;
    bit          rd_rand;
    logic [31:0] rd_fixed;
    bit          rsp_rand;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    function automatic logic [103:0] pack(input cmd_t c);
        return {SRC_ID, (c.write ? c.wdata : 32'h0), c.addr, 5'b00000, c.dm, c.write};
    endfunction

    // Cycle counter, responder data and optional random response backpressure.
    task automatic env_loop();
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            reg_rdata = rd_rand ? $urandom : rd_fixed;
            hist[cyc] = reg_rdata;
            if (rsp_rand) rsp_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // Reference model: commands leave in acceptance order, one read in flight,
    // read data is whatever the responder drove RD_LAT cycles after the issue cycle.
    task automatic monitor();
        cmd_t c;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                outstanding = 0;
                prev_access = 0;
                prev_rv     = 0;
                prev_rr     = 0;
                continue;
            end
            if (reg_access) begin
                chk("mon access spacing", 128'(prev_access), 128'(0));
                chk("mon access during read", 128'(outstanding), 128'(0));
                chk("mon access expected", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    c = exp_q.pop_front();
                    chk("mon packet", 128'(reg_packet), 128'(pack(c)));
                    if (c.write) n_wr_issued++;
                    else begin
                        outstanding = 1;
                        issue_cyc   = cyc;
                    end
                end
            end else begin
                chk("mon idle packet", 128'(reg_packet), 128'(0));
            end
            if (rsp_valid) begin
                chk("mon rsp expected", 128'(outstanding), 128'(1));
                if (outstanding) begin
                    if (!prev_rv) begin
                        chk("mon rsp latency", 128'(cyc), 128'(issue_cyc + RD_LAT + 1));
                        chk("mon rsp rdata", 128'(rsp_rdata), 128'(hist[issue_cyc + RD_LAT]));
                    end else begin
                        chk("mon rsp hold", 128'(rsp_rdata), 128'(prev_rd));
                    end
                    if (rsp_ready) outstanding = 0;
                end
            end else begin
                if (prev_rv) chk("mon rsp dropped", 128'(prev_rr), 128'(1));
                if (outstanding && cyc >= issue_cyc + RD_LAT + 1) begin
                    chk("mon rsp on time", 128'(rsp_valid), 128'(1));
                    outstanding = 0;
                end
            end
            prev_access = reg_access;
            prev_rv     = rsp_valid;
            prev_rr     = rsp_ready;
            prev_rd     = rsp_rdata;
        end
    endtask

    task automatic watchdog();
        #400000;
        $display("FAIL watchdog: run still active, required finished");
        $fatal(1);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input logic w, input logic [1:0] dm, input logic [31:0] a,
                        input logic [31:0] d, output int acc_cyc);
        cmd_t c;
        bit   acc;
        int   budget;
        acc = 0;
        budget = 0;
        acc_cyc = -1;
        c.write = w; c.dm = dm; c.addr = a; c.wdata = d;
        cmd_valid = 1; cmd_write = w; cmd_datamode = dm; cmd_addr = a; cmd_wdata = d;
        while (!acc && budget < 200) begin
            @(negedge clk);
            acc = cmd_ready;
            if (acc) begin
                acc_cyc = cyc;
                exp_q.push_back(c);
                n_accepted++;
            end
            @(posedge clk);
            #1;
            budget++;
        end
        cmd_valid = 0;
        chk("push accepted", 128'(acc), 128'(1));
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy && !rsp_valid) begin
                ok = 1;
                break;
            end
        end
        chk(name, 128'(ok), 128'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_access(output bit found, output int c, output logic [103:0] p);
        found = 0; c = -1; p = '0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (reg_access) begin
                found = 1; c = cyc; p = reg_packet;
                break;
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " cmd_ready"},  128'(cmd_ready),  128'(1));
        chk({tag, " rsp_valid"},  128'(rsp_valid),  128'(0));
        chk({tag, " rsp_rdata"},  128'(rsp_rdata),  128'(0));
        chk({tag, " reg_access"}, 128'(reg_access), 128'(0));
        chk({tag, " reg_packet"}, 128'(reg_packet), 128'(0));
        chk({tag, " busy"},       128'(busy),       128'(0));
        chk({tag, " wr_count"},   128'(wr_count),   128'(0));
    endtask

    vec_t        vt [5];
    int          acc;
    int          acc2;
    int          c;
    int          hs_cyc;
    int          base;
    int          n_wr_rand;
    bit          found;
    bit          any_acc;
    bit          any_rsp;
    logic [103:0] p;
    logic [31:0] r0;

    initial begin
        cmd_valid = 0; cmd_write = 0; cmd_datamode = 0; cmd_addr = 0; cmd_wdata = 0;
        rsp_ready = 0; reg_rdata = 0; rst = 0;
        n_pass = 0; n_total = 0; cyc = 0; n_wr_issued = 0; n_accepted = 0;
        outstanding = 0; issue_cyc = 0; prev_access = 0; prev_rv = 0; prev_rr = 0; prev_rd = 0;
        rd_rand = 1; rd_fixed = 0; rsp_rand = 0;

        vt[0] = '{1'b1, 2'b10, 32'h0000_0004, 32'hA5A5_0001, 32'h0,         32'hA5A5_0001, 32'h0};
        vt[1] = '{1'b0, 2'b10, 32'h0000_0008, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF};
        vt[2] = '{1'b1, 2'b00, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF, 32'h0};
        vt[3] = '{1'b0, 2'b11, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0,         32'h0000_0001};
        vt[4] = '{1'b1, 2'b01, 32'h8000_0000, 32'h0000_0000, 32'h0,         32'h0000_0000, 32'h0};

        fork
            env_loop();
            monitor();
            watchdog();
        join_none

        // Reset state
        #1 rst = 1;
        #1;
        chk_reset_vals("reset");
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Table vectors: single write / single read with immediate response
        foreach (vt[i]) begin
            rd_rand = 0; rd_fixed = vt[i].rdata; rsp_rand = 0; rsp_ready = 1;
            push(vt[i].write, vt[i].dm, vt[i].addr, vt[i].wdata, acc);
            wait_access(found, c, p);
            chk("vec access seen", 128'(found), 128'(1));
            chk("vec access latency", 128'(c - acc), 128'(2));
            chk("vec pkt write", 128'(p[0]), 128'(vt[i].write));
            chk("vec pkt datamode", 128'(p[2:1]), 128'(vt[i].dm));
            chk("vec pkt ctrlmode", 128'(p[7:3]), 128'(0));
            chk("vec pkt dstaddr", 128'(p[39:8]), 128'(vt[i].addr));
            chk("vec pkt data", 128'(p[71:40]), 128'(vt[i].exp_data));
            chk("vec pkt srcaddr", 128'(p[103:72]), 128'(SRC_ID));
            @(negedge clk);
            chk("vec access one cycle", 128'(reg_access), 128'(0));
            if (!vt[i].write) begin
                found = 0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (rsp_valid) begin found = 1; break; end
                end
                chk("vec rsp seen", 128'(found), 128'(1));
                chk("vec rsp rdata", 128'(rsp_rdata), 128'(vt[i].exp_rsp));
                @(negedge clk);
                chk("vec rsp one cycle", 128'(rsp_valid), 128'(0));
            end
            wait_idle("vec idle");
        end
        chk("wr_count after table", 128'(wr_count), 128'(3));
        chk("rsp_rdata kept", 128'(rsp_rdata), 128'(32'h0000_0001));

        // Response backpressure with a queued write behind the read
        rd_rand = 1; rsp_ready = 0;
        push(1'b0, 2'b10, 32'h0000_0010, 32'h0, acc);
        push(1'b1, 2'b10, 32'h0000_0014, 32'hCAFE_0014, acc2);
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin found = 1; break; end
        end
        chk("bp rsp seen", 128'(found), 128'(1));
        r0 = rsp_rdata;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp rsp_valid held", 128'(rsp_valid), 128'(1));
            chk("bp rsp_rdata held", 128'(rsp_rdata), 128'(r0));
            chk("bp no access", 128'(reg_access), 128'(0));
        end
        @(posedge clk);
        #1 rsp_ready = 1;
        hs_cyc = cyc;
        wait_access(found, c, p);
        chk("bp write issued", 128'(found), 128'(1));
        chk("bp write after handshake", 128'(c), 128'(hs_cyc + 2));
        chk("bp write addr", 128'(p[39:8]), 128'(32'h0000_0014));
        wait_idle("bp idle");

        // FIFO full and wrap-around: stall the FSM in RESP, then offer 6 writes
        rsp_ready = 0;
        push(1'b0, 2'b00, 32'h0000_0040, 32'h0, acc);
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin found = 1; break; end
        end
        chk("full stall rsp", 128'(found), 128'(1));
        @(posedge clk);
        #1;
        base = n_accepted;
        c = int'(wr_count);
        acc2 = n_wr_issued;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    push(1'b1, 2'b01, 32'h0000_0100 + 32'(4 * i), 32'h1000_0000 + 32'(i), acc);
            end
            begin
                repeat (8) @(negedge clk);
                chk("full accepted count", 128'(n_accepted - base), 128'(4));
                chk("full cmd_ready low", 128'(cmd_ready), 128'(0));
                chk("full busy", 128'(busy), 128'(1));
                @(posedge clk);
                #1 rsp_ready = 1;
            end
        join
        wait_idle("full idle");
        chk("full wr_count", 128'(int'(wr_count) - c), 128'(6));
        chk("full writes issued", 128'(n_wr_issued - acc2), 128'(6));

        // wr_count saturation
        force dut.wr_count = 16'hFFFE;
        @(posedge clk);
        #1 release dut.wr_count;
        chk("sat preload", 128'(wr_count), 128'(16'hFFFE));
        push(1'b1, 2'b00, 32'h0000_0200, 32'h1, acc);
        wait_idle("sat idle 1");
        chk("sat first", 128'(wr_count), 128'(16'hFFFF));
        push(1'b1, 2'b00, 32'h0000_0204, 32'h2, acc);
        push(1'b1, 2'b00, 32'h0000_0208, 32'h3, acc);
        wait_idle("sat idle 2");
        chk("sat final", 128'(wr_count), 128'(16'hFFFF));

        // Reset while a read is in WAIT with two writes queued
        rsp_ready = 1;
        push(1'b0, 2'b00, 32'h0000_0020, 32'h0, acc);
        push(1'b1, 2'b00, 32'h0000_0024, 32'h24, acc);
        push(1'b1, 2'b00, 32'h0000_0028, 32'h28, acc);
        chk("mid busy before reset", 128'(busy), 128'(1));
        chk("mid no access in wait", 128'(reg_access), 128'(0));
        #1 rst = 1;
        #1;
        chk_reset_vals("mid reset");
        repeat (2) @(posedge clk);
        #1 rst = 0;
        any_acc = 0;
        any_rsp = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            any_acc = any_acc | reg_access;
            any_rsp = any_rsp | rsp_valid;
        end
        chk("post reset no access", 128'(any_acc), 128'(0));
        chk("post reset no rsp", 128'(any_rsp), 128'(0));
        chk("post reset wr_count", 128'(wr_count), 128'(0));
        @(posedge clk);
        #1;

        // Randomized traffic against the reference model
        rd_rand = 1; rsp_rand = 1; n_wr_rand = 0;
        for (int i = 0; i < 150; i++) begin
            logic        w;
            int          gap;
            w = 1'($urandom);
            push(w, 2'($urandom), $urandom, $urandom, acc);
            if (w) n_wr_rand++;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        rsp_rand = 0;
        rsp_ready = 1;
        wait_idle("rand drain");
        chk("rand queue drained", 128'(exp_q.size()), 128'(0));
        chk("rand wr_count", 128'(wr_count), 128'(n_wr_rand));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
